// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: applies PC-1 to an incoming key, then walks
// key_round through the 16 rounds. It supplies C/D, the rotate amount, the
// direction and a data-valid strobe, and takes key_round's registered C/D back.
module des_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_key_dv,
  input  logic [63:0] i_key,
  input  logic        i_encrypt,
  input  logic        i_stall,
  input  logic [27:0] i_c,
  input  logic [27:0] i_d,
  output logic        o_ready,
  output logic [27:0] o_c,
  output logic [27:0] o_d,
  output logic        o_shift_indicator,
  output logic        o_encrypt,
  output logic        o_kr_dv,
  output logic [3:0]  o_round,
  output logic        o_done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  // Bit i set means encrypt round i rotates by 1 (rounds 1, 2, 9, 16).
  localparam logic [15:0] SHIFT1_MASK = 16'h8103;

  state_t      state_q, state_nxt;
  logic [3:0]  round_q;
  logic        enc_q;
  logic [27:0] c0_q, d0_q;
  logic        load;
  logic [3:0]  sched_idx;
  logic [55:0] pc1_cd;
  logic        unused_parity_bits;

  // PC-1 written out with DES bit numbers: DES bit n lives at i_key[64-n].
  assign pc1_cd = {
    i_key[64-57], i_key[64-49], i_key[64-41], i_key[64-33], i_key[64-25], i_key[64-17], i_key[64-9],
    i_key[64-1],  i_key[64-58], i_key[64-50], i_key[64-42], i_key[64-34], i_key[64-26], i_key[64-18],
    i_key[64-10], i_key[64-2],  i_key[64-59], i_key[64-51], i_key[64-43], i_key[64-35], i_key[64-27],
    i_key[64-19], i_key[64-11], i_key[64-3],  i_key[64-60], i_key[64-52], i_key[64-44], i_key[64-36],
    i_key[64-63], i_key[64-55], i_key[64-47], i_key[64-39], i_key[64-31], i_key[64-23], i_key[64-15],
    i_key[64-7],  i_key[64-62], i_key[64-54], i_key[64-46], i_key[64-38], i_key[64-30], i_key[64-22],
    i_key[64-14], i_key[64-6],  i_key[64-61], i_key[64-53], i_key[64-45], i_key[64-37], i_key[64-29],
    i_key[64-21], i_key[64-13], i_key[64-5],  i_key[64-28], i_key[64-20], i_key[64-12], i_key[64-4]
  };

  // Parity bits take no part in the schedule.
  assign unused_parity_bits = ^{i_key[64-8],  i_key[64-16], i_key[64-24], i_key[64-32],
                                i_key[64-40], i_key[64-48], i_key[64-56], i_key[64-64]};

  assign load = (state_q == IDLE) && i_key_dv;

  // Decrypt round r uses the encrypt entry for 16-r; round 0 maps to entry 0
  // (rotate 1), which undoes the left rotate applied when the key was stored.
  assign sched_idx = enc_q ? round_q : (4'd0 - round_q);

  assign o_shift_indicator = SHIFT1_MASK[sched_idx];
  assign o_encrypt         = enc_q;
  assign o_round           = round_q;

  // Round 0 starts from the stored C0/D0; later rounds use key_round's feedback.
  assign o_c = (state_q == RUN && round_q != 4'd0) ? i_c : c0_q;
  assign o_d = (state_q == RUN && round_q != 4'd0) ? i_d : d0_q;

  // State register plus the stored start values, direction and round index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      enc_q   <= 1'b0;
      c0_q    <= 28'd0;
      d0_q    <= 28'd0;
    end else begin
      state_q <= state_nxt;
      if (load) begin
        enc_q   <= i_encrypt;
        round_q <= 4'd0;
        if (i_encrypt) begin
          c0_q <= pc1_cd[55:28];
          d0_q <= pc1_cd[27:0];
        end else begin
          c0_q <= {pc1_cd[54:28], pc1_cd[55]};
          d0_q <= {pc1_cd[26:0],  pc1_cd[27]};
        end
      end else if (o_kr_dv) begin
        round_q <= round_q + 4'd1;
      end
    end
  end

  // Next state and handshake outputs; a stall simply withholds the round strobe.
  always_comb begin
    state_nxt = state_q;
    o_ready   = 1'b0;
    o_kr_dv   = 1'b0;
    o_done    = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_key_dv) state_nxt = RUN;
      end
      RUN: begin
        o_kr_dv = !i_stall;
        if (!i_stall && round_q == LAST_ROUND) begin
          o_done    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
